fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 13 +
 rtl/fetch_btb.sv | 35 +++
 rtl/fetch_unit.sv | 58 +++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared constants, widths and the sequential-PC helper for the fetch stage.
package fetch_unit_pkg;
  localparam int WORD_W = 16;
  localparam int BTB_ENTRIES = 4;
  localparam int BTB_IDX_W = 2;
  localparam int BTB_TAG_W = WORD_W - BTB_IDX_W - 1;
  localparam logic [WORD_W-1:0] PC_RESET = 16'h0000;
  localparam logic [WORD_W-1:0] NOP_INSTR = 16'h0000;
  localparam logic [WORD_W-1:0] PC_STEP = 16'd2;
  function automatic logic [WORD_W-1:0] pc_seq(input logic [WORD_W-1:0] pc);
    return pc + PC_STEP;
  endfunction
endpackage

// File: rtl/fetch_btb.sv
// fetch_btb: 4-entry direct-mapped branch target buffer; a write becomes visible on the next cycle.
module fetch_btb
  import fetch_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] lookup_pc,
  output logic              hit,
  output logic [WORD_W-1:0] target,
  input  logic              we,
  input  logic [WORD_W-1:0] write_pc,
  input  logic [WORD_W-1:0] write_target
);
  logic [BTB_TAG_W-1:0] tags [BTB_ENTRIES];
  logic [WORD_W-1:0] tgts [BTB_ENTRIES];
  logic [BTB_ENTRIES-1:0] valid;
  logic [BTB_IDX_W-1:0] rd_idx, wr_idx;
  logic unused_bits;
  assign unused_bits = lookup_pc[0] ^ write_pc[0];
  assign rd_idx = lookup_pc[BTB_IDX_W:1];
  assign wr_idx = write_pc[BTB_IDX_W:1];
  assign hit = valid[rd_idx] && (tags[rd_idx] == lookup_pc[WORD_W-1:BTB_IDX_W+1]);
  assign target = tgts[rd_idx];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid <= '0;
    else if (we) valid[wr_idx] <= 1'b1;
  end
  // Tag/target storage is qualified by the valid bits, so it carries no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      tags[wr_idx] <= write_pc[WORD_W-1:BTB_IDX_W+1];
      tgts[wr_idx] <= write_target;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, BTB-predicted next PC and IF/ID pipeline register.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [WORD_W-1:0] flush_target,
  input  logic [WORD_W-1:0] flush_pc,
  input  logic [WORD_W-1:0] imem_data,
  output logic [WORD_W-1:0] imem_addr,
  output logic [WORD_W-1:0] ifid_instr,
  output logic [WORD_W-1:0] ifid_pc,
  output logic [WORD_W-1:0] ifid_one_away,
  output logic [WORD_W-1:0] ifid_btb,
  output logic              ifid_valid
);
  logic [WORD_W-1:0] pc, pc_plus, btb_target, pred_pc;
  logic btb_hit;
  fetch_btb u_btb (
    .clk(clk),
    .rst(rst),
    .lookup_pc(pc),
    .hit(btb_hit),
    .target(btb_target),
    .we(flush),
    .write_pc(flush_pc),
    .write_target(flush_target)
  );
  assign imem_addr = pc;
  assign pc_plus = pc_seq(pc);
  assign pred_pc = btb_hit ? btb_target : pc_plus;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= PC_RESET;
      ifid_instr <= NOP_INSTR;
      ifid_pc <= '0;
      ifid_one_away <= '0;
      ifid_btb <= '0;
      ifid_valid <= 1'b0;
    end else if (flush) begin
      pc <= flush_target;
      ifid_instr <= NOP_INSTR;
      ifid_pc <= '0;
      ifid_one_away <= '0;
      ifid_btb <= '0;
      ifid_valid <= 1'b0;
    end else if (!stall) begin
      pc <= pred_pc;
      ifid_instr <= imem_data;
      ifid_pc <= pc;
      ifid_one_away <= pc_plus;
      ifid_btb <= pred_pc;
      ifid_valid <= 1'b1;
    end
  end
endmodule
